bram_fifo_ctrl: RTL and testbench
=================================

BRAM_FIFO_CTRL -- requirements
Module: bram_fifo_ctrl

Interface
REQ-001 SHALL have parameter CLOCK_INFO, default 'b0 (std_clock_info_t): clock_edge selects the active clock edge; rising for the default.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: entry width in bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10: RAM depth is 2**ADDR_WIDTH entries.
REQ-004 SHALL have parameter READ_LATENCY, default 1: RAM read latency in cycles; legal values 1 (no RAM output register) or 2 (RAM output register enabled).
REQ-005 SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
  clk  in  1  clock
  rst  in  1  asynchronous active-high reset
  in_valid  in  1  producer has data
  in_ready  out  1  block accepts data
  in_data  in  DATA_WIDTH  write payload
  out_valid  out  1  output holds data
  out_ready  in  1  consumer takes data
  out_data  out  DATA_WIDTH  head entry
  ram_write_enable  out  1  RAM write strobe
  ram_write_addr  out  ADDR_WIDTH  RAM write address
  ram_write_data  out  DATA_WIDTH  RAM write data
  ram_read_enable  out  1  RAM read strobe
  ram_read_output_enable  out  1  RAM output-register enable
  ram_read_addr  out  ADDR_WIDTH  RAM read address
  ram_read_data  in  DATA_WIDTH  RAM read return
  count  out  ADDR_WIDTH+2  total entries held

Function
REQ-006 SHALL accept an entry when in_valid && in_ready at the active edge: ram_write_enable=1, ram_write_addr=wr_ptr, ram_write_data=in_data; wr_ptr then increments.
REQ-007 SHALL drive in_ready = (ram_count < 2**ADDR_WIDTH), decoded from registers only; no combinational path from in_valid or out_ready.
REQ-008 SHALL keep a prefetch buffer of SKID_DEPTH = READ_LATENCY+1 entries, with out_valid = (skid_count != 0) and out_data = the skid head.
REQ-009 SHALL issue a read (ram_read_enable=1, ram_read_addr=rd_ptr, rd_ptr++, ram_count--) when ram_count != 0 and skid_count + inflight - pop < SKID_DEPTH, where pop = out_valid && out_ready.
REQ-010 SHALL track inflight reads through a READ_LATENCY-deep valid pipeline and capture ram_read_data into the skid buffer READ_LATENCY cycles after issue.
REQ-011 SHALL drive ram_read_output_enable as ram_read_enable delayed by one cycle.
REQ-012 SHALL make an entry written in cycle N readable no earlier than cycle N+1, so write and read never target the same address in the same cycle.
REQ-013 SHALL assert out_valid READ_LATENCY+2 cycles after acceptance into an empty block.
REQ-014 SHALL sustain one entry per cycle when in_valid=1 and out_ready=1.
REQ-015 SHALL keep out_data stable while out_valid && !out_ready.
REQ-016 SHALL let wr_ptr and rd_ptr wrap modulo 2**ADDR_WIDTH.
REQ-017 SHALL keep ram_count ADDR_WIDTH+1 bits wide.
REQ-018 SHALL report count = ram_count + inflight + skid_count.
REQ-019 SHALL, on a simultaneous accept and read issue, apply both: ram_count is unchanged.
REQ-020 SHALL, when full, not accept input in a cycle that issues a read; in_ready rises the following cycle.
REQ-021 SHALL deliver entries in acceptance order, with no loss or duplication under any in_valid/out_ready pattern.

Reset
REQ-022 SHALL, while rst=1, hold in_ready, out_valid, ram_write_enable, ram_read_enable and ram_read_output_enable at 0 and count at 0.
REQ-023 SHALL zero all pointers, counts and the inflight pipeline on reset.
REQ-024 SHALL discard RAM data returning after a reset taken mid-operation.
REQ-025 SHALL not clear RAM contents on reset.
REQ-026 SHALL assert in_ready in the first active cycle after rst deasserts.

Configuration
REQ-027 SHALL, with BRAM_FIFO_CTRL_HIGH_WATER_EN defined, add output high_water (ADDR_WIDTH+2 bits): the maximum count since reset, reset value 0, updated every cycle.
REQ-028 SHALL, with BRAM_FIFO_CTRL_HIGH_WATER_EN undefined, omit the high_water port and its logic.

Verification (ADDR_WIDTH=4, DATA_WIDTH=32, READ_LATENCY=1 unless noted)
REQ-029 SHALL cover: reset, then push 0xA5A50001 at cycle 0 with out_ready=1 -> out_valid=1 with out_data=0xA5A50001 at cycle 3, count returns to 0.
REQ-030 SHALL cover: out_ready=0, in_valid held for 20 words -> exactly 18 accepted, in_ready=0 afterwards, count=18.
REQ-031 SHALL cover: stream words 0..99 with in_valid=out_ready=1 -> outputs 0..99 in order, one per cycle after the initial latency, in_ready never 0; repeated with READ_LATENCY=2.
REQ-032 SHALL cover: random out_ready pattern over 1000 words -> scoreboard shows no loss, duplication or reorder, and out_data stable while stalled.
REQ-033 SHALL cover: rst pulse with 5 entries held and 1 read in flight -> out_valid=0, count=0; next push 0x00001234 emerges alone.
REQ-034 SHALL cover, with the macro defined: push 10 words, drain, push 3 words -> high_water=10.

Source files
------------

// File: rtl/bram_fifo_ctrl.sv
// ============================================================================
// Module   : bram_fifo_ctrl
// Purpose  : FIFO controller around an external simple-dual-port block RAM,
//            with a small prefetch (skid) buffer that hides the RAM read latency.
// Options  : define BRAM_FIFO_CTRL_HIGH_WATER_EN to add the high_water output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bram_fifo_ctrl_pkg;
  typedef struct packed {
    logic clock_edge;  // 0: rising edge, 1: falling edge
  } std_clock_info_t;
endpackage

module bram_fifo_ctrl
  import bram_fifo_ctrl_pkg::*;
#(
  parameter std_clock_info_t CLOCK_INFO   = '0,
  parameter int              DATA_WIDTH   = 32,
  parameter int              ADDR_WIDTH   = 10,
  parameter int              READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  ram_write_enable,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  output logic                  ram_read_enable,
  output logic                  ram_read_output_enable,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
`ifdef BRAM_FIFO_CTRL_HIGH_WATER_EN
  output logic [ADDR_WIDTH+1:0] high_water,
`endif
  output logic [ADDR_WIDTH+1:0] count
);

  localparam int SKID_DEPTH = READ_LATENCY + 1;
  localparam int SW         = $clog2(SKID_DEPTH);
  localparam int CW         = $clog2(SKID_DEPTH + 1);
  localparam int CNTW       = ADDR_WIDTH + 2;

  logic w_clk;
  assign w_clk = clk ^ CLOCK_INFO.clock_edge;

  logic [ADDR_WIDTH-1:0]   r_wr_ptr;
  logic [ADDR_WIDTH-1:0]   r_rd_ptr;
  logic [ADDR_WIDTH:0]     r_ram_count;
  logic [READ_LATENCY-1:0] r_pipe;
  logic                    r_read_en_d;
  logic [DATA_WIDTH-1:0]   r_skid_mem [0:SKID_DEPTH-1];
  logic [SW-1:0]           r_skid_head;
  logic [SW-1:0]           r_skid_tail;
  logic [CW-1:0]           r_skid_count;

  logic          w_push;
  logic          w_pop;
  logic          w_issue;
  logic          w_capture;
  logic [CW-1:0] w_inflight;
  logic [CW:0]   w_occ;
  logic [CW:0]   w_lim;

  function automatic logic [SW-1:0] skid_next(input logic [SW-1:0] p);
    return (p == SW'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      w_inflight = w_inflight + CW'(r_pipe[i]);
    end
  end

  // ram_count never exceeds the depth, so its MSB alone flags "full"
  assign in_ready  = !rst && !r_ram_count[ADDR_WIDTH];
  assign out_valid = (r_skid_count != '0);
  assign out_data  = r_skid_mem[r_skid_head];

  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign w_capture = r_pipe[READ_LATENCY-1];

  // Reserve a skid slot for every read in flight before issuing another
  always_comb begin
    w_occ   = {1'b0, r_skid_count} + {1'b0, w_inflight};
    w_lim   = (CW+1)'(SKID_DEPTH) + {{CW{1'b0}}, w_pop};
    w_issue = !rst && (r_ram_count != '0) && (w_occ < w_lim);
  end

  assign ram_write_enable       = w_push;
  assign ram_write_addr         = r_wr_ptr;
  assign ram_write_data         = in_data;
  assign ram_read_enable        = w_issue;
  assign ram_read_addr          = r_rd_ptr;
  assign ram_read_output_enable = r_read_en_d;

  assign count = CNTW'(r_ram_count) + CNTW'(w_inflight) + CNTW'(r_skid_count);

  always_ff @(posedge w_clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_ram_count  <= '0;
      r_pipe       <= '0;
      r_read_en_d  <= 1'b0;
      r_skid_head  <= '0;
      r_skid_tail  <= '0;
      r_skid_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_issue})
        2'b10:   r_ram_count <= r_ram_count + 1'b1;
        2'b01:   r_ram_count <= r_ram_count - 1'b1;
        default: r_ram_count <= r_ram_count;
      endcase

      r_pipe[0] <= w_issue;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
      r_read_en_d <= w_issue;

      if (w_capture) begin
        r_skid_tail <= skid_next(r_skid_tail);
      end
      if (w_pop) begin
        r_skid_head <= skid_next(r_skid_head);
      end
      case ({w_capture, w_pop})
        2'b10:   r_skid_count <= r_skid_count + 1'b1;
        2'b01:   r_skid_count <= r_skid_count - 1'b1;
        default: r_skid_count <= r_skid_count;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the counters
  always_ff @(posedge w_clk) begin
    if (w_capture) begin
      r_skid_mem[r_skid_tail] <= ram_read_data;
    end
  end

`ifdef BRAM_FIFO_CTRL_HIGH_WATER_EN
  logic [CNTW-1:0] r_high_water;

  always_ff @(posedge w_clk or posedge rst) begin
    if (rst) begin
      r_high_water <= '0;
    end else if (count > r_high_water) begin
      r_high_water <= count;
    end
  end

  assign high_water = r_high_water;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bram_fifo_ctrl.sv
// Testbench for bram_fifo_ctrl: two instances (READ_LATENCY 1 and 2) share
// stimulus; a scoreboard/occupancy model plus directed sequences check them.
`default_nettype none

module tb_bram_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_data;

  wire [1:0]       in_ready, out_valid, wen, ren, roe;
  wire [1:0][31:0] out_data, wdata, rdata;
  wire [1:0][3:0]  waddr, raddr;
  wire [1:0][5:0]  cnt;
`ifdef BRAM_FIFO_CTRL_HIGH_WATER_EN
  wire [1:0][5:0]  hw;
`endif

  always #5 clk = ~clk;

  bram_fifo_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1)) u_rl1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready[0]), .in_data(in_data),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]),
    .ram_write_enable(wen[0]), .ram_write_addr(waddr[0]), .ram_write_data(wdata[0]),
    .ram_read_enable(ren[0]), .ram_read_output_enable(roe[0]),
    .ram_read_addr(raddr[0]), .ram_read_data(rdata[0]),
`ifdef BRAM_FIFO_CTRL_HIGH_WATER_EN
    .high_water(hw[0]),
`endif
    .count(cnt[0])
  );

  bram_fifo_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2)) u_rl2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready[1]), .in_data(in_data),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]),
    .ram_write_enable(wen[1]), .ram_write_addr(waddr[1]), .ram_write_data(wdata[1]),
    .ram_read_enable(ren[1]), .ram_read_output_enable(roe[1]),
    .ram_read_addr(raddr[1]), .ram_read_data(rdata[1]),
`ifdef BRAM_FIFO_CTRL_HIGH_WATER_EN
    .high_water(hw[1]),
`endif
    .count(cnt[1])
  );

  // Block RAM models: instance 0 unregistered output, instance 1 with output register
  logic [31:0]       mem [2][16];
  logic [1:0][31:0]  stage, oreg;
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (wen[k]) mem[k][waddr[k]] <= wdata[k];
      if (ren[k]) stage[k] <= mem[k][raddr[k]];
      if (roe[k]) oreg[k] <= stage[k];
    end
  end
  assign rdata[0] = stage[0];
  assign rdata[1] = oreg[1];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: accepted words in order; occupancy = accepted - delivered
  logic [31:0] sbm [2][4096];
  int          sb_wr [2];
  int          sb_rd [2];
  logic        stalled [2];
  logic [31:0] held [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      sb_wr[k] = 0; sb_rd[k] = 0; stalled[k] = 1'b0; held[k] = '0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          chk("rst_in_ready", 32'(in_ready[k]), 32'd0);
          chk("rst_out_valid", 32'(out_valid[k]), 32'd0);
          chk("rst_count", 32'(cnt[k]), 32'd0);
          chk("rst_strobes", 32'({wen[k], ren[k], roe[k]}), 32'd0);
          sb_rd[k]   = sb_wr[k];
          stalled[k] = 1'b0;
        end else begin
          chk("count", 32'(cnt[k]), 32'(sb_wr[k] - sb_rd[k]));
          if (stalled[k]) begin
            chk("stall_valid", 32'(out_valid[k]), 32'd1);
            chk("stall_data", out_data[k], held[k]);
          end
          if (out_valid[k]) begin
            if (sb_rd[k] == sb_wr[k]) chk("spurious_out", 32'(out_valid[k]), 32'd0);
            else chk("order", out_data[k], sbm[k][sb_rd[k] % 4096]);
          end
          stalled[k] = out_valid[k] && !out_ready;
          held[k]    = out_data[k];
          if (out_valid[k] && out_ready && sb_rd[k] != sb_wr[k]) sb_rd[k]++;
          if (in_valid && in_ready[k]) begin
            sbm[k][sb_wr[k] % 4096] = in_data;
            sb_wr[k]++;
          end
        end
      end
    end
  end

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        ir;
    logic        ov0;
    logic [5:0]  c0;
    logic        ov1;
    logic [5:0]  c1;
    logic [31:0] od;
  } vec_t;

  vec_t vec [6];
  int   acc [2];
  int   nout [2];
  int   first [2];
  int   last [2];
  int   drops [2];
  int   start_wr [2];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drain();
    int t;
    t         = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((cnt[0] != 6'd0 || cnt[1] != 6'd0) && t < 200) begin
      step();
      t++;
    end
    @(negedge clk);
    chk("drain_rl1", 32'(cnt[0]), 32'd0);
    chk("drain_rl2", 32'(cnt[1]), 32'd0);
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec[0] = '{1'b1, 32'hA5A50001, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 32'hA5A50001};
    vec[1] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 6'd1, 1'b0, 6'd1, 32'hA5A50001};
    vec[2] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 6'd1, 1'b0, 6'd1, 32'hA5A50001};
    vec[3] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 6'd1, 1'b0, 6'd1, 32'hA5A50001};
    vec[4] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 6'd0, 1'b1, 6'd1, 32'hA5A50001};
    vec[5] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 32'hA5A50001};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) step();
    rst = 1'b0;

    // Single push latency, applied from the vector table
    for (int i = 0; i < 6; i++) begin
      in_valid = vec[i].iv; in_data = vec[i].d; out_ready = vec[i].ordy;
      @(negedge clk);
      chk("tbl_ready_rl1", 32'(in_ready[0]), 32'(vec[i].ir));
      chk("tbl_ready_rl2", 32'(in_ready[1]), 32'(vec[i].ir));
      chk("tbl_valid_rl1", 32'(out_valid[0]), 32'(vec[i].ov0));
      chk("tbl_count_rl1", 32'(cnt[0]), 32'(vec[i].c0));
      chk("tbl_valid_rl2", 32'(out_valid[1]), 32'(vec[i].ov1));
      chk("tbl_count_rl2", 32'(cnt[1]), 32'(vec[i].c1));
      if (vec[i].ov0) chk("tbl_data_rl1", out_data[0], vec[i].od);
      if (vec[i].ov1) chk("tbl_data_rl2", out_data[1], vec[i].od);
      step();
    end

    // Fill with consumer stalled: RAM depth plus skid depth
    do_reset();
    acc[0] = 0; acc[1] = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = 32'h100 + 32'(i); out_ready = 1'b0;
      @(negedge clk);
      if (in_ready[0]) acc[0]++;
      if (in_ready[1]) acc[1]++;
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("fill_accepted_rl1", 32'(acc[0]), 32'd18);
    chk("fill_accepted_rl2", 32'(acc[1]), 32'd19);
    chk("fill_ready_rl1", 32'(in_ready[0]), 32'd0);
    chk("fill_ready_rl2", 32'(in_ready[1]), 32'd0);
    chk("fill_count_rl1", 32'(cnt[0]), 32'd18);
    chk("fill_count_rl2", 32'(cnt[1]), 32'd19);
    step();
    drain();

    // Streaming at full rate
    do_reset();
    for (int k = 0; k < 2; k++) begin
      nout[k] = 0; first[k] = -1; last[k] = -1; drops[k] = 0;
    end
    for (int c = 0; c < 110; c++) begin
      in_valid = (c < 100); in_data = 32'(c); out_ready = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (in_valid && !in_ready[k]) drops[k]++;
        if (out_valid[k]) begin
          if (nout[k] == 0) first[k] = c;
          last[k] = c;
          chk("stream_data", out_data[k], 32'(nout[k]));
          nout[k]++;
        end
      end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      chk("stream_ready_drops", 32'(drops[k]), 32'd0);
      chk("stream_count", 32'(nout[k]), 32'd100);
      chk("stream_first", 32'(first[k]), 32'(k + 3));
      chk("stream_span", 32'(last[k] - first[k]), 32'd99);
    end
    drain();

    // Random handshakes
    do_reset();
    start_wr[0] = sb_wr[0]; start_wr[1] = sb_wr[1];
    for (int c = 0; c < 2500; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = $urandom;
      out_ready = $urandom_range(0, 1) == 1;
      step();
    end
    drain();
    for (int k = 0; k < 2; k++) begin
      chk("rand_enough_words", 32'(sb_wr[k] - start_wr[k] >= 1000), 32'd1);
      chk("rand_leftover", 32'(sb_wr[k] - sb_rd[k]), 32'd0);
    end

    // Reset while holding entries with a read in flight
    do_reset();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 32'h200 + 32'(i); out_ready = 1'b0;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    rst = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_count_rl1", 32'(cnt[0]), 32'd0);
    chk("midrst_count_rl2", 32'(cnt[1]), 32'd0);
    step();
    rst = 1'b0;
    in_valid = 1'b1; in_data = 32'h00001234;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    nout[0] = 0; nout[1] = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (out_valid[k]) begin
          chk("midrst_data", out_data[k], 32'h00001234);
          nout[k]++;
        end
      end
      step();
    end
    chk("midrst_outputs_rl1", 32'(nout[0]), 32'd1);
    chk("midrst_outputs_rl2", 32'(nout[1]), 32'd1);

`ifdef BRAM_FIFO_CTRL_HIGH_WATER_EN
    do_reset();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 32'h300 + 32'(i); out_ready = 1'b0;
      step();
    end
    drain();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'h400 + 32'(i); out_ready = 1'b0;
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    @(negedge clk);
    chk("high_water_rl1", 32'(hw[0]), 32'd10);
    chk("high_water_rl2", 32'(hw[1]), 32'd10);
    step();
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
